// File: rtl/spi1_master.sv
// SPI1 command initiator: serialises one bus command as a mode-0 SPI frame, waits for the
// target's ready line, and for reads clocks a second frame to fetch the result byte.
// Optional ready timeout is compiled in when SPI1_MASTER_TIMEOUT_EN is defined.
module spi1_master #(
  parameter int unsigned SCK_DIV     = 2,
  parameter int unsigned READY_GUARD = 4,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk16_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rw_ni,
  input  logic [16:0] cmd_addr_i,
  input  logic [7:0]  cmd_data_i,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  rd_data_o,
  output logic        spi_sck_o,
  output logic        spi_cs_no,
  output logic        spi_tx_o,
  input  logic        spi_rx_i,
  input  logic        spi_ready_i
);

  localparam int unsigned GuardW = (READY_GUARD > 1) ? $clog2(READY_GUARD) : 1;
  localparam logic [7:0]        DivLoad   = 8'(SCK_DIV - 1);
  localparam logic [GuardW-1:0] GuardLoad = GuardW'(READY_GUARD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGuard,
    StWait,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        div_q, div_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              rw_q, rw_d;
  logic              frame_b_q, frame_b_d;
  logic [1:0]        sync_q, sync_d;
`ifdef SPI1_MASTER_TIMEOUT_EN
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
`endif

  logic       accept;
  logic [4:0] last_bit;

  assign cmd_ready_o = (state_q == StIdle) || (state_q == StDone);
  assign accept      = cmd_valid_i && cmd_ready_o;
  // Frame B is 8 bits; Frame A is 24 bits for reads, 32 for writes.
  assign last_bit    = frame_b_q ? 5'd7 : (rw_q ? 5'd23 : 5'd31);

  assign done_o    = (state_q == StDone);
  assign rd_data_o = rd_data_q;
  assign spi_sck_o = sck_q;
  assign spi_cs_no = cs_n_q;
  assign spi_tx_o  = shift_q[31];
`ifdef SPI1_MASTER_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Next-state logic for the frame sequencer, shifter and counters.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    guard_d   = guard_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    rw_d      = rw_q;
    frame_b_d = frame_b_q;
    sync_d    = {sync_q[0], spi_ready_i};
`ifdef SPI1_MASTER_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif

    case (state_q)
      StIdle: ;
      StSetup: begin
        if (div_q == 8'd0) begin
          div_d   = DivLoad;
          state_d = StShift;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      StShift: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DivLoad;
          if (!sck_q) begin
            // Rising edge: MISO is captured in the same cycle SCK goes high.
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], spi_rx_i};
          end else begin
            // Falling edge: MOSI advances while SCK is low.
            sck_d = 1'b0;
            if (bit_cnt_q == last_bit) begin
              state_d = StHold;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              shift_d   = {shift_q[30:0], 1'b0};
            end
          end
        end
      end
      StHold: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          cs_n_d  = 1'b1;
          shift_d = '0;
          guard_d = GuardLoad;
          state_d = StGuard;
        end
      end
      StGuard: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GuardW'(1);
        end else begin
          state_d = StWait;
`ifdef SPI1_MASTER_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      StWait: begin
        if (sync_q[1]) begin
          if (rw_q && !frame_b_q) begin
            // Read: clock out zeros to fetch the result byte.
            state_d   = StSetup;
            shift_d   = '0;
            frame_b_d = 1'b1;
            cs_n_d    = 1'b0;
            div_d     = DivLoad;
            bit_cnt_d = '0;
          end else begin
            state_d = StDone;
            if (frame_b_q) begin
              rd_data_d = rx_q;
            end
`ifdef SPI1_MASTER_TIMEOUT_EN
            err_d = 1'b0;
`endif
          end
`ifdef SPI1_MASTER_TIMEOUT_EN
        end else if (wait_cnt_q == 16'(TIMEOUT)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef SPI1_MASTER_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase

    // Acceptance is possible in IDLE and DONE and overrides the case above.
    if (accept) begin
      state_d   = StSetup;
      shift_d   = {cmd_rw_ni, 6'b0, cmd_addr_i[16], cmd_addr_i[15:0], cmd_data_i};
      rw_d      = cmd_rw_ni;
      frame_b_d = 1'b0;
      cs_n_d    = 1'b0;
      sck_d     = 1'b0;
      div_d     = DivLoad;
      bit_cnt_d = '0;
`ifdef SPI1_MASTER_TIMEOUT_EN
      err_d = 1'b0;
`endif
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk16_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      guard_q   <= '0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      rw_q      <= 1'b0;
      frame_b_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      guard_q   <= guard_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      rw_q      <= rw_d;
      frame_b_q <= frame_b_d;
      sync_q    <= sync_d;
    end
  end

`ifdef SPI1_MASTER_TIMEOUT_EN
  // Ready-timeout counter and error flag.
  always_ff @(posedge clk16_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi1_master.sv
// Directed bench for spi1_master: SPI target model on the pins plus per-scenario tasks.
module tb_spi1_master;

  logic        clk16_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_rw_ni;
  logic [16:0] cmd_addr_i;
  logic [7:0]  cmd_data_i;
  logic        done_o;
  logic        err_o;
  logic [7:0]  rd_data_o;
  logic        spi_sck_o;
  logic        spi_cs_no;
  logic        spi_tx_o;
  logic        spi_rx_i;
  logic        spi_ready_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Target model state
  logic [7:0]  tgt_byte = 8'h00;
  logic [7:0]  miso_sh  = 8'h00;
  logic [31:0] mosi_bits = '0;
  int          mosi_cnt = 0;
  int          sck_edges = 0;
  int          cs_fall_cnt = 0;
  int          cs_low_cnt = 0;
  int          done_cnt = 0;
  int          mode0_viol = 0;
  logic        tx_prev = 1'b0;

  spi1_master #(
    .SCK_DIV    (2),
    .READY_GUARD(4),
    .TIMEOUT    (64)
  ) dut (
    .clk16_i    (clk16_i),
    .rst_ni     (rst_ni),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_rw_ni  (cmd_rw_ni),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .done_o     (done_o),
    .err_o      (err_o),
    .rd_data_o  (rd_data_o),
    .spi_sck_o  (spi_sck_o),
    .spi_cs_no  (spi_cs_no),
    .spi_tx_o   (spi_tx_o),
    .spi_rx_i   (spi_rx_i),
    .spi_ready_i(spi_ready_i)
  );

  always #5 clk16_i = ~clk16_i;

  assign spi_rx_i = miso_sh[7];

  always @(negedge spi_cs_no) begin
    miso_sh = tgt_byte;
    cs_fall_cnt++;
  end

  always @(negedge spi_sck_o) if (!spi_cs_no) miso_sh = {miso_sh[6:0], 1'b0};

  always @(posedge spi_sck_o) begin
    sck_edges++;
    if (!spi_cs_no) begin
      mosi_bits = {mosi_bits[30:0], spi_tx_o};
      mosi_cnt++;
    end
  end

  always @(negedge clk16_i) begin
    if (!spi_cs_no) cs_low_cnt++;
    if (done_o) done_cnt++;
    if (rst_ni && (spi_tx_o !== tx_prev) && spi_sck_o) mode0_viol++;
    tx_prev = spi_tx_o;
  end

  task automatic clear_mon();
    mosi_bits   = '0;
    mosi_cnt    = 0;
    cs_fall_cnt = 0;
    cs_low_cnt  = 0;
  endtask

  // Returns at the negedge of cycle N+1 after acceptance at cycle N.
  task automatic send_cmd(input logic rw, input logic [16:0] addr, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge clk16_i);
    while (!cmd_ready_o && n < 1000) begin
      @(negedge clk16_i);
      n++;
    end
    tests_run++;
    if (n >= 1000) begin
      tests_failed++;
      $display("FAIL send_cmd: cmd_ready_o got %b, required 1 within 1000 cycles", cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_rw_ni   = rw;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    @(negedge clk16_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done_o && cycles < budget) begin
      @(negedge clk16_i);
      cycles++;
    end
    tests_run++;
    if (!done_o) begin
      tests_failed++;
      $display("FAIL wait_done: done_o got 0, required 1 within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    tests_run += 7;
    if (cmd_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_cmd_ready got %b req 1", cmd_ready_o); end
    if (done_o !== 1'b0) begin tests_failed++; $display("FAIL rst_done got %b req 0", done_o); end
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL rst_err got %b req 0", err_o); end
    if (rd_data_o !== 8'h00) begin tests_failed++; $display("FAIL rst_rd_data got %h req 00", rd_data_o); end
    if (spi_sck_o !== 1'b0) begin tests_failed++; $display("FAIL rst_sck got %b req 0", spi_sck_o); end
    if (spi_cs_no !== 1'b1) begin tests_failed++; $display("FAIL rst_cs got %b req 1", spi_cs_no); end
    if (spi_tx_o !== 1'b0) begin tests_failed++; $display("FAIL rst_tx got %b req 0", spi_tx_o); end
  endtask

  task automatic test_write();
    int cyc;
    clear_mon();
    mode0_viol = 0;
    send_cmd(1'b0, 17'h1_8000, 8'hA5);
    tests_run += 3;
    if (spi_cs_no !== 1'b0) begin tests_failed++; $display("FAIL wr_cs_n1 got %b req 0", spi_cs_no); end
    if (spi_tx_o !== 1'b0) begin tests_failed++; $display("FAIL wr_tx_n1 got %b req 0", spi_tx_o); end
    if (cmd_ready_o !== 1'b0) begin tests_failed++; $display("FAIL wr_busy got %b req 0", cmd_ready_o); end
    wait_done(600, cyc);
    tests_run += 6;
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL wr_err got %b req 0", err_o); end
    if (cmd_ready_o !== 1'b1) begin tests_failed++; $display("FAIL wr_ready_at_done got %b req 1", cmd_ready_o); end
    if (mosi_cnt != 32) begin tests_failed++; $display("FAIL wr_bits got %0d req 32", mosi_cnt); end
    if (mosi_bits !== 32'h0180_00A5) begin tests_failed++; $display("FAIL wr_mosi got %h req 018000a5", mosi_bits); end
    if (cs_low_cnt != 132) begin tests_failed++; $display("FAIL wr_cs_low got %0d req 132", cs_low_cnt); end
    if (mode0_viol != 0) begin tests_failed++; $display("FAIL wr_mode0 got %0d req 0", mode0_viol); end
  endtask

  task automatic test_read();
    int cyc;
    clear_mon();
    tgt_byte = 8'h5C;
    send_cmd(1'b1, 17'h0_E810, 8'hFF);
    tests_run++;
    if (spi_tx_o !== 1'b1) begin tests_failed++; $display("FAIL rd_tx_n1 got %b req 1", spi_tx_o); end
    wait_done(800, cyc);
    tests_run += 5;
    if (rd_data_o !== 8'h5C) begin tests_failed++; $display("FAIL rd_data got %h req 5c", rd_data_o); end
    if (mosi_cnt != 32) begin tests_failed++; $display("FAIL rd_bits got %0d req 32", mosi_cnt); end
    if (mosi_bits !== 32'h80E8_1000) begin tests_failed++; $display("FAIL rd_mosi got %h req 80e81000", mosi_bits); end
    if (cs_fall_cnt != 2) begin tests_failed++; $display("FAIL rd_frames got %0d req 2", cs_fall_cnt); end
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL rd_err got %b req 0", err_o); end
    @(negedge clk16_i);
    tests_run += 2;
    if (done_o !== 1'b0) begin tests_failed++; $display("FAIL rd_done_pulse got %b req 0", done_o); end
    if (rd_data_o !== 8'h5C) begin tests_failed++; $display("FAIL rd_hold got %h req 5c", rd_data_o); end
  endtask

  task automatic test_ready_wait();
    int n, edges0, done0, cyc;
    clear_mon();
    spi_ready_i = 1'b0;
    send_cmd(1'b0, 17'h0_0123, 8'h3C);
    n = 0;
    while (spi_cs_no !== 1'b1 && n < 600) begin
      @(negedge clk16_i);
      n++;
    end
    edges0 = sck_edges;
    done0  = done_cnt;
    repeat (50) @(negedge clk16_i);
    tests_run += 3;
    if (n >= 600) begin tests_failed++; $display("FAIL wait_frame_end got cs=%b req 1", spi_cs_no); end
    if (sck_edges != edges0) begin tests_failed++; $display("FAIL wait_sck got %0d edges req 0", sck_edges - edges0); end
    if (done_cnt != done0) begin tests_failed++; $display("FAIL wait_done_early got %0d req 0", done_cnt - done0); end
    spi_ready_i = 1'b1;
    @(negedge clk16_i);
    cyc = 1;
    wait_done(20, n);
    cyc += n;
    tests_run += 2;
    if (cyc != 3) begin tests_failed++; $display("FAIL wait_latency got %0d req 3", cyc); end
    if (mosi_bits !== 32'h0001_233C) begin tests_failed++; $display("FAIL wait_mosi got %h req 0001233c", mosi_bits); end
  endtask

  task automatic test_input_change();
    int cyc;
    clear_mon();
    send_cmd(1'b0, 17'h1_ABCD, 8'h96);
    cyc = 0;
    while (!done_o && cyc < 600) begin
      cmd_addr_i = 17'($urandom);
      cmd_data_i = 8'($urandom);
      cmd_rw_ni  = 1'($urandom);
      @(negedge clk16_i);
      cyc++;
    end
    tests_run += 2;
    if (!done_o) begin tests_failed++; $display("FAIL chg_done got 0 req 1"); end
    if (mosi_bits !== 32'h01AB_CD96) begin tests_failed++; $display("FAIL chg_mosi got %h req 01abcd96", mosi_bits); end
  endtask

  task automatic test_reset_mid();
    int n, done0, cyc;
    clear_mon();
    send_cmd(1'b0, 17'h1_2345, 8'h77);
    n = 0;
    while (mosi_cnt < 13 && n < 600) begin
      @(negedge clk16_i);
      n++;
    end
    rst_ni = 1'b0;
    #1;
    tests_run += 4;
    if (n >= 600) begin tests_failed++; $display("FAIL mid_reach_bit13 got %0d bits req 13", mosi_cnt); end
    if (spi_cs_no !== 1'b1) begin tests_failed++; $display("FAIL mid_cs got %b req 1", spi_cs_no); end
    if (spi_sck_o !== 1'b0) begin tests_failed++; $display("FAIL mid_sck got %b req 0", spi_sck_o); end
    if (cmd_ready_o !== 1'b1) begin tests_failed++; $display("FAIL mid_ready got %b req 1", cmd_ready_o); end
    done0 = done_cnt;
    repeat (2) @(negedge clk16_i);
    rst_ni = 1'b1;
    repeat (200) @(negedge clk16_i);
    tests_run++;
    if (done_cnt != done0) begin tests_failed++; $display("FAIL mid_no_done got %0d req 0", done_cnt - done0); end
    clear_mon();
    send_cmd(1'b0, 17'h0_0F0F, 8'h5A);
    wait_done(600, cyc);
    tests_run += 2;
    if (mosi_bits !== 32'h000F_0F5A) begin tests_failed++; $display("FAIL mid_next_mosi got %h req 000f0f5a", mosi_bits); end
    if (cs_low_cnt != 132) begin tests_failed++; $display("FAIL mid_next_cs_low got %0d req 132", cs_low_cnt); end
  endtask

`ifdef SPI1_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    tgt_byte = 8'hC3;
    clear_mon();
    send_cmd(1'b1, 17'h0_0042, 8'h00);
    wait_done(800, cyc);
    tests_run++;
    if (rd_data_o !== 8'hC3) begin tests_failed++; $display("FAIL to_pre_read got %h req c3", rd_data_o); end
    spi_ready_i = 1'b0;
    tgt_byte = 8'h18;
    clear_mon();
    send_cmd(1'b1, 17'h1_0042, 8'h00);
    wait_done(800, cyc);
    tests_run += 3;
    if (err_o !== 1'b1) begin tests_failed++; $display("FAIL to_err got %b req 1", err_o); end
    if (rd_data_o !== 8'hC3) begin tests_failed++; $display("FAIL to_rd_keep got %h req c3", rd_data_o); end
    if (mosi_bits !== 32'h0081_0042) begin tests_failed++; $display("FAIL to_mosi got %h req 00810042", mosi_bits); end
    repeat (20) @(negedge clk16_i);
    tests_run += 2;
    if (cs_fall_cnt != 1) begin tests_failed++; $display("FAIL to_frames got %0d req 1", cs_fall_cnt); end
    if (mosi_cnt != 24) begin tests_failed++; $display("FAIL to_bits got %0d req 24", mosi_cnt); end
    spi_ready_i = 1'b1;
  endtask
`endif

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_rw_ni   = 1'b0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    spi_ready_i = 1'b1;
    repeat (3) @(negedge clk16_i);
    test_reset();
    rst_ni = 1'b1;
    repeat (2) @(negedge clk16_i);
    test_write();
    test_read();
    test_ready_wait();
    test_input_change();
    test_reset_mid();
`ifdef SPI1_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
